uart_rx_buffered: RTL and testbench
===================================

Name: uart_rx_buffered

Overview:
- 8N1 UART receiver with a noise-tolerant bit sampler and an 8-entry receive FIFO.
- Sits at the board's serial input pin and pairs with uart_tx on the other end of the link.
- Adds a 2-FF input synchronizer, 3-sample majority voting, start-glitch rejection and framing-error detection.
- Buffers received bytes so the logic-analyzer command parser can consume them at its own pace.

Parameters:
- CLKS_PER_BIT, 5207, i_Clock cycles per serial bit; must be >= 4.
- FIFO_DEPTH, 8, receive FIFO entries; power of two, >= 2.

Ports:
- i_Clock  in  1  system clock (100 MHz).
- i_Reset  in  1  asynchronous, active-high reset.
- i_Rx_Serial  in  1  asynchronous serial line; idles high.
- i_Rd_En  in  1  pop the FIFO head; ignored when o_Empty=1.
- i_Clr_Err  in  1  clears the sticky o_Overrun flag.
- o_Rx_Byte  out  8  FIFO head (show-ahead); valid while o_Empty=0.
- o_Rx_DV  out  1  one-cycle pulse when a good byte is pushed.
- o_Empty  out  1  FIFO empty.
- o_Full  out  1  FIFO full.
- o_Count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_Frame_Err  out  1  one-cycle pulse on a bad stop bit.
- o_Overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
- o_Parity_Err  out  1  one-cycle pulse on parity mismatch; tied 0 without UART_RX_PARITY_EN.

Behaviour:
- Reset values:
  - Synchronizer flops = 1.
  - State = IDLE; all counters and FIFO pointers = 0.
  - o_Empty=1; all other outputs 0.
  - Reset asserted mid-frame aborts the frame; that partial byte is never pushed.
- Sampling:
  - rx_s is the 2-FF synchronized input.
  - MID = (CLKS_PER_BIT-1)/2 (integer division).
  - A bit value is the majority of rx_s taken at clk_cnt = MID-1, MID and MID+1; the decision is registered at MID+1.
  - clk_cnt runs 0..CLKS_PER_BIT-1 and restarts at 0 on every bit boundary.
- FSM:
  - IDLE: rx_s=0 -> START, clk_cnt=0.
  - START: at the decision point, voted 0 -> continue, clk_cnt keeps running to the bit end, then DATA. Voted 1 -> glitch; return to IDLE with no flags.
  - DATA: 8 bits, LSB first, shifted into a shift register; after bit 7 -> PARITY if enabled, else STOP.
  - STOP: voted 1 -> push byte into the FIFO (or drop it and set overrun), then IDLE. Voted 0 -> pulse o_Frame_Err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1 so a break condition is not re-detected as a start bit; then IDLE.
  - Return to IDLE happens at the stop-bit decision point, not at the end of the stop bit. This allows resync on back-to-back frames.
- FIFO:
  - Push occurs in the cycle after the stop decision; o_Rx_DV pulses in that same cycle.
  - Push while full and i_Rd_En=0: byte dropped, o_Overrun set, o_Rx_DV stays 0.
  - Push while full with i_Rd_En=1 in the same cycle: both pop and push happen, no overrun, o_Count unchanged.
  - Push while empty: o_Rx_Byte valid in the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; o_Full = (o_Count == FIFO_DEPTH).
  - o_Overrun clears on i_Clr_Err. If an overrun and i_Clr_Err coincide, set wins.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1: a PARITY state samples one extra bit after the data bits.
  - Mismatch against XOR(data bits) -> o_Parity_Err pulse at the stop decision. The byte is discarded; the frame still proceeds through STOP.
  - A frame with both errors pulses both o_Parity_Err and o_Frame_Err.
- Undefined:
  - No PARITY state; o_Parity_Err is constant 0.

Test Plan:
- Clean frame:
  - Setup: CLKS_PER_BIT=16; send 0xA5 as 8N1.
  - Required: o_Rx_DV pulses once; o_Rx_Byte=0xA5; o_Count=1.
  - Then pulse i_Rd_En: o_Empty=1.
- Start glitch: 5-cycle low pulse on i_Rx_Serial -> no push, no flags, FSM back in IDLE.
- Framing error and break:
  - Send 0x3C with stop=0, then hold the line low for 40 bit times, then send 0x55.
  - Required: one o_Frame_Err pulse; no push for 0x3C and no further frames during the low hold; 0x55 received correctly.
- Overrun:
  - Send 9 bytes 0x00..0x08 with no reads.
  - Required: o_Full=1 after the 8th byte; o_Overrun=1 after the 9th; reads return 0x00..0x07.
  - i_Clr_Err clears o_Overrun.
- Full with simultaneous read: FIFO full; assert i_Rd_En in the push cycle of byte 0x99 -> o_Overrun stays 0; 0x99 is the last entry read.
- Reset and parity:
  - Assert i_Reset during data bit 4 of 0xFF; release, then send 0x12 -> only 0x12 received.
  - With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> o_Parity_Err pulses and nothing is pushed.

Source files
------------

// File: rtl/uart_rx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_buffered
// Purpose  : 8N1 UART receiver with 2-FF sync, 3-sample majority voting,
//            start-glitch rejection, framing-error detection and a receive FIFO.
//            Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 5207,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Rx_Serial,
  input  logic                          i_Rd_En,
  input  logic                          i_Clr_Err,
  output logic [7:0]                    o_Rx_Byte,
  output logic                          o_Rx_DV,
  output logic                          o_Empty,
  output logic                          o_Full,
  output logic [$clog2(FIFO_DEPTH):0]   o_Count,
  output logic                          o_Frame_Err,
  output logic                          o_Overrun,
  output logic                          o_Parity_Err
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_MID   = (CLKS_PER_BIT - 1) / 2;
  localparam logic [c_CNT_W-1:0] c_SMP0 = c_CNT_W'(c_MID - 1);
  localparam logic [c_CNT_W-1:0] c_SMP1 = c_CNT_W'(c_MID);
  localparam logic [c_CNT_W-1:0] c_DEC  = c_CNT_W'(c_MID + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
  localparam logic [c_PTR_W:0]   c_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY  = 3'd5
`endif
  } state_t;

  logic               r_rx_meta, r_rx_s, r_s0, r_s1;
  state_t             r_state, w_state_nx;
  logic [c_CNT_W-1:0] r_clk_cnt, w_cnt_nx;
  logic [2:0]         r_bit_idx, w_idx_nx;
  logic [7:0]         r_shift, w_shift_nx;
  logic               r_push_req, w_push_nx;
  logic               r_frame_err, w_ferr_nx;
  logic               r_overrun;
  logic               w_vote, w_dec, w_end, w_parity_bad, w_perr_nx;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_push, w_pop;

  assign w_vote = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
  assign w_dec  = (r_clk_cnt == c_DEC);
  assign w_end  = (r_clk_cnt == c_LAST);

`ifdef UART_RX_PARITY_EN
  logic r_par_bit, w_par_nx, r_parity_err;
  // Even parity: the received parity bit must equal the XOR of the data bits.
  assign w_parity_bad = (r_par_bit != ^r_shift);
  assign o_Parity_Err = r_parity_err;
`else
  assign w_parity_bad = 1'b0;
  assign o_Parity_Err = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = w_end ? '0 : r_clk_cnt + c_ONE;
    w_idx_nx   = r_bit_idx;
    w_shift_nx = r_shift;
    w_push_nx  = 1'b0;
    w_ferr_nx  = 1'b0;
    w_perr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nx   = r_par_bit;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (!r_rx_s) w_state_nx = S_START;
      end
      S_START: begin
        if (w_dec && w_vote) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (w_end) begin
          w_state_nx = S_DATA;
          w_idx_nx   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_dec) w_shift_nx = {w_vote, r_shift[7:1]};
        if (w_end) begin
          w_idx_nx = r_bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (r_bit_idx == 3'd7) w_state_nx = S_PARITY;
`else
          if (r_bit_idx == 3'd7) w_state_nx = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_dec) w_par_nx = w_vote;
        if (w_end) w_state_nx = S_STOP;
      end
`endif
      // Leave at the decision point so a back-to-back start bit is caught.
      S_STOP: begin
        if (w_dec) begin
          w_cnt_nx  = '0;
          w_perr_nx = w_parity_bad;
          if (w_vote) begin
            w_state_nx = S_IDLE;
            w_push_nx  = !w_parity_bad;
          end else begin
            w_ferr_nx  = 1'b1;
            w_state_nx = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        w_cnt_nx = '0;
        if (r_rx_s) w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_s0        <= 1'b1;
      r_s1        <= 1'b1;
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_push_req  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_meta   <= i_Rx_Serial;
      r_rx_s      <= r_rx_meta;
      if (r_clk_cnt == c_SMP0) r_s0 <= r_rx_s;
      if (r_clk_cnt == c_SMP1) r_s1 <= r_rx_s;
      r_state     <= w_state_nx;
      r_clk_cnt   <= w_cnt_nx;
      r_bit_idx   <= w_idx_nx;
      r_shift     <= w_shift_nx;
      r_push_req  <= w_push_nx;
      r_frame_err <= w_ferr_nx;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= w_par_nx;
      r_parity_err <= w_perr_nx;
`endif
    end
  end

  // r_shift only changes inside DATA, so it still holds the byte in the push cycle.
  assign w_pop  = i_Rd_En & ~o_Empty;
  assign w_push = r_push_req & (~o_Full | w_pop);

  always_ff @(posedge i_Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (r_push_req && o_Full && !w_pop) r_overrun <= 1'b1;
      else if (i_Clr_Err)                 r_overrun <= 1'b0;
    end
  end

  assign o_Empty     = (r_count == '0);
  assign o_Full      = (r_count == c_FULL);
  assign o_Count     = r_count;
  assign o_Rx_DV     = w_push;
  assign o_Rx_Byte   = o_Empty ? 8'h00 : r_mem[r_rd_ptr];
  assign o_Frame_Err = r_frame_err;
  assign o_Overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_buffered
// Purpose  : Directed self-checking bench for uart_rx_buffered with a byte
//            scoreboard; 16 clocks per bit, 8-entry FIFO.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_buffered;
  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, rx, rd_en, clr_err;
  logic [7:0] rx_byte;
  logic       rx_dv, empty, full, frame_err, overrun, parity_err;
  logic [$clog2(DEPTH):0] count;

  int n_cmp = 0, n_bad = 0;
  int dv_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int exp_dv = 0;
  logic [7:0] sb[$];
`ifdef UART_RX_PARITY_EN
  logic par_force_bad = 1'b0;
`endif

  uart_rx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Rx_Serial (rx),
    .i_Rd_En     (rd_en),
    .i_Clr_Err   (clr_err),
    .o_Rx_Byte   (rx_byte),
    .o_Rx_DV     (rx_dv),
    .o_Empty     (empty),
    .o_Full      (full),
    .o_Count     (count),
    .o_Frame_Err (frame_err),
    .o_Overrun   (overrun),
    .o_Parity_Err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_dv)      dv_cnt++;
    if (frame_err)  ferr_cnt++;
    if (parity_err) perr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string tag);
    logic [7:0] e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=<scoreboard empty>", tag, rx_byte);
    end else begin
      e = sb.pop_front();
      check(tag, rx_byte, e);
    end
  endtask

  task automatic read_one(input string tag);
    @(negedge clk);
    check({tag, "_not_empty"}, empty, 0);
    expect_head(tag);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // rd_at_push raises i_Rd_En for exactly the push cycle: 12 clocks after the
  // stop-bit edge (2 sync stages + 1 start detect + MID+1 + 1 registered decision).
  task automatic send(input logic [7:0] d, input logic stop_v, input bit rd_at_push);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_force_bad ? ~(^d) : ^d);
`endif
    rx = stop_v;
    if (rd_at_push) begin
      tick(12);
      rd_en = 1'b1;
      @(negedge clk);
      check("simul_rd_dv", rx_dv, 1);
      expect_head("simul_rd_head");
      tick(1);
      rd_en = 1'b0;
      tick(CPB - 13);
    end else begin
      tick(CPB);
    end
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_dv", rx_dv, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_perr", parity_err, 0);
    check("rst_byte", rx_byte, 0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Clean frame
    sb.push_back(8'hA5); exp_dv++;
    send(8'hA5, 1'b1, 0);
    tick(2);
    check("clean_dv_cnt", dv_cnt, exp_dv);
    check("clean_count", count, 1);
    read_one("clean_byte");
    check("clean_empty_after_rd", empty, 1);

    // Start glitch
    rx = 1'b0; tick(5); rx = 1'b1;
    tick(3 * CPB);
    check("glitch_dv_cnt", dv_cnt, exp_dv);
    check("glitch_ferr_cnt", ferr_cnt, 0);
    check("glitch_count", count, 0);

    // Framing error followed by a 40-bit break, then a good byte
    send(8'h3C, 1'b0, 0);
    tick(40 * CPB);
    check("break_ferr_cnt", ferr_cnt, 1);
    check("break_no_push", dv_cnt, exp_dv);
    rx = 1'b1;
    tick(2 * CPB);
    sb.push_back(8'h55); exp_dv++;
    send(8'h55, 1'b1, 0);
    tick(2);
    check("after_break_ferr_cnt", ferr_cnt, 1);
    check("after_break_dv_cnt", dv_cnt, exp_dv);
    read_one("after_break_byte");

    // Overrun: nine bytes with no reads
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin sb.push_back(8'(i)); exp_dv++; end
      send(8'(i), 1'b1, 0);
      tick(2);
      if (i == 7) begin
        check("ovr_full_at_8", full, 1);
        check("ovr_clear_at_8", overrun, 0);
      end
    end
    check("ovr_set_at_9", overrun, 1);
    check("ovr_count", count, DEPTH);
    check("ovr_dv_cnt", dv_cnt, exp_dv);
    for (int i = 0; i < 8; i++) read_one("ovr_read");
    check("ovr_empty", empty, 1);
    check("ovr_sticky", overrun, 1);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Full FIFO with a read in the push cycle
    for (int i = 0; i < 8; i++) begin
      sb.push_back(8'h10 + 8'(i)); exp_dv++;
      send(8'h10 + 8'(i), 1'b1, 0);
    end
    tick(2);
    check("simul_full", full, 1);
    sb.push_back(8'h99); exp_dv++;
    send(8'h99, 1'b1, 1);
    tick(2);
    check("simul_no_ovr", overrun, 0);
    check("simul_count", count, DEPTH);
    check("simul_dv_cnt", dv_cnt, exp_dv);
    for (int i = 0; i < 8; i++) read_one("simul_read");
    check("simul_empty", empty, 1);

    // Reset during data bit 4 of 0xFF
    rx = 1'b0; tick(CPB);
    rx = 1'b1; tick(4 * CPB + CPB / 2);
    rst = 1'b1; tick(3); rst = 1'b0;
    tick(5 * CPB);
    check("rstmid_dv_cnt", dv_cnt, exp_dv);
    check("rstmid_empty", empty, 1);
    sb.push_back(8'h12); exp_dv++;
    send(8'h12, 1'b1, 0);
    tick(2);
    check("rstmid_count", count, 1);
    check("rstmid_dv_after", dv_cnt, exp_dv);
    read_one("rstmid_byte");

`ifdef UART_RX_PARITY_EN
    par_force_bad = 1'b1;
    send(8'h07, 1'b1, 0);
    par_force_bad = 1'b0;
    tick(2);
    check("parity_err_cnt", perr_cnt, 1);
    check("parity_no_push", count, 0);
    check("parity_dv_cnt", dv_cnt, exp_dv);
`else
    check("parity_tied_low", perr_cnt, 0);
`endif
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
